// File: rtl/irq_controller.sv
// N-source interrupt controller: per-source synchroniser, edge capture, pending/overflow
// tracking and fixed-priority (lowest index) service towards the rcpu irq handshake.
module irq_controller #(
  parameter int N_SRC       = 4,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        srcReq,
  input  logic [N_SRC*DATA_W-1:0] srcData,
  input  logic [N_SRC-1:0]        srcEn,
  input  logic                    intEn,
  input  logic [ADDR_W-1:0]       vecBase,
  input  logic                    turnOffIRQ,
  output logic                    irq,
  output logic [DATA_W-1:0]       intData,
  output logic [ADDR_W-1:0]       intAddr,
  output logic [3:0]              intSrc,
  output logic [N_SRC-1:0]        pending,
  output logic [N_SRC-1:0]        overflow
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  state_t             state, state_n;
  logic [N_SRC-1:0]   sync_p [SYNC_STAGES];
  logic [N_SRC-1:0]   hist;
  logic [N_SRC-1:0]   evt;
  logic [N_SRC-1:0]   elig;
  logic [WARM_W-1:0]  warm_cnt;
  logic               warm;
  logic [DATA_W-1:0]  data_q [N_SRC];
  logic [3:0]         sel;
  logic [DATA_W-1:0]  sel_data;
  logic               load;
  logic               ack;

  assign warm = (warm_cnt == WARM_W'(SYNC_STAGES));
  assign evt  = sync_p[SYNC_STAGES-1] & ~hist & {N_SRC{warm}};
  assign elig = pending & srcEn;

  // History is forced high until the synchroniser has refilled after reset, so a
  // line already high at release needs a low-then-high before it counts as an event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      hist     <= '0;
      warm_cnt <= '0;
    end else begin
      sync_p[0] <= srcReq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      hist <= warm ? sync_p[SYNC_STAGES-1] : '1;
      if (!warm) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  always_comb begin
    sel      = '0;
    sel_data = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel      = 4'(i);
        sel_data = data_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    ack     = 1'b0;
    case (state)
      IDLE:   if (intEn && (|elig)) begin
                load    = 1'b1;
                state_n = ASSERT;
              end
      ASSERT: if (turnOffIRQ) begin
                ack     = 1'b1;
                state_n = GAP;
              end
      GAP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq     <= 1'b0;
      intSrc  <= '0;
      intData <= '0;
      intAddr <= '0;
    end else if (load) begin
      irq     <= 1'b1;
      intSrc  <= sel;
      intData <= sel_data;
      intAddr <= vecBase + ADDR_W'(sel);
    end else if (ack) begin
      irq <= 1'b0;
    end
  end

  // An event arriving with its own ack re-arms the source: set beats clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending  <= '0;
      overflow <= '0;
      for (int i = 0; i < N_SRC; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (ack && (intSrc == 4'(i))) begin
          pending[i]  <= 1'b0;
          overflow[i] <= 1'b0;
        end
        if (evt[i] && srcEn[i]) begin
          if (!pending[i] || (ack && (intSrc == 4'(i)))) begin
            pending[i] <= 1'b1;
            data_q[i]  <= srcData[i*DATA_W +: DATA_W];
          end else begin
            overflow[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expected services are queued at stimulus time
// and compared when irq rises.
module tb_irq_controller;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  srcReq;
  logic [N*DW-1:0] srcData;
  logic [N-1:0]  srcEn;
  logic          intEn;
  logic [AW-1:0] vecBase;
  logic          turnOffIRQ;
  logic          irq;
  logic [DW-1:0] intData;
  logic [AW-1:0] intAddr;
  logic [3:0]    intSrc;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;

  irq_controller #(.N_SRC(N), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .srcReq(srcReq), .srcData(srcData), .srcEn(srcEn),
    .intEn(intEn), .vecBase(vecBase), .turnOffIRQ(turnOffIRQ), .irq(irq),
    .intData(intData), .intAddr(intAddr), .intSrc(intSrc), .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    src;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } svc_t;

  svc_t sb_q[$];
  svc_t exp_svc;
  int   checks = 0;
  int   errors = 0;
  logic irq_d  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_svc(input int s, input logic [DW-1:0] d);
    svc_t e;
    e.src  = 4'(s);
    e.data = d;
    e.addr = vecBase + AW'(s);
    sb_q.push_back(e);
  endtask

  task automatic pulse(input int i, input logic [DW-1:0] d);
    srcData[i*DW +: DW] = d;
    srcReq[i] = 1'b1;
    tick();
    srcReq[i] = 1'b0;
  endtask

  task automatic ack_irq();
    turnOffIRQ = 1'b1;
    tick();
    turnOffIRQ = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!irq && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(irq), 64'd1);
  endtask

  // Counts irq-low cycles following an ack (the ack cycle itself included).
  task automatic gap_len(input string tag);
    int lows = 1;
    while (!irq && lows < 10) begin
      tick();
      if (!irq) lows++;
    end
    check(tag, 64'(lows), 64'd2);
  endtask

  always @(negedge clk) begin
    if (irq && !irq_d) begin
      if (sb_q.size() == 0) begin
        check("unexpected_irq", 64'd1, 64'd0);
      end else begin
        exp_svc = sb_q.pop_front();
        check("sb_src",  64'(intSrc),  64'(exp_svc.src));
        check("sb_data", 64'(intData), 64'(exp_svc.data));
        check("sb_addr", 64'(intAddr), 64'(exp_svc.addr));
      end
    end
    irq_d = irq;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; srcReq = '0; srcData = '0; srcEn = '0; intEn = 1'b0;
    vecBase = '0; turnOffIRQ = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check("rst_irq",      64'(irq),      64'd0);
    check("rst_pending",  64'(pending),  64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_intSrc",   64'(intSrc),   64'd0);
    check("rst_intAddr",  64'(intAddr),  64'd0);
    check("rst_intData",  64'(intData),  64'd0);
    srcEn = 4'hF; intEn = 1'b1; vecBase = 32'h0000_0100;
    repeat (4) tick();

    // Single source, latency and ack
    srcData[1*DW +: DW] = 16'h00A5;
    expect_svc(1, 16'h00A5);
    srcReq[1] = 1'b1;
    tick();
    srcReq[1] = 1'b0;
    tick(); tick();
    check("t1_irq_edge3", 64'(irq), 64'd0);
    tick();
    check("t1_irq_edge4", 64'(irq), 64'd1);
    check("t1_pending",   64'(pending), 64'b0010);
    ack_irq();
    check("t1_irq_off",   64'(irq), 64'd0);
    check("t1_pend_clr",  64'(pending), 64'd0);
    repeat (3) tick();

    // Simultaneous sources: priority and minimum gap
    srcData[0*DW +: DW] = 16'h0A0A;
    srcData[3*DW +: DW] = 16'h3333;
    expect_svc(0, 16'h0A0A);
    expect_svc(3, 16'h3333);
    srcReq = 4'b1001;
    tick();
    srcReq = '0;
    wait_irq("t2_irq0");
    check("t2_first_src", 64'(intSrc), 64'd0);
    ack_irq();
    gap_len("t2_gap");
    check("t2_second_src", 64'(intSrc), 64'd3);
    ack_irq();
    repeat (3) tick();

    // Overflow: second event while pending keeps first data
    expect_svc(2, 16'h1111);
    pulse(2, 16'h1111);
    wait_irq("t3_irq");
    pulse(2, 16'h2222);
    repeat (4) tick();
    check("t3_overflow", 64'(overflow), 64'b0100);
    check("t3_data",     64'(intData),  64'h1111);
    check("t3_irq_held", 64'(irq),      64'd1);
    ack_irq();
    check("t3_ovf_clr",  64'(overflow), 64'd0);
    check("t3_pend_clr", 64'(pending),  64'd0);
    repeat (3) tick();

    // Disabled source, then global enable gating
    srcEn = 4'b1011;
    pulse(2, 16'h5555);
    repeat (6) tick();
    check("t4_masked_pend", 64'(pending), 64'd0);
    check("t4_masked_irq",  64'(irq),     64'd0);
    srcEn = 4'hF;
    intEn = 1'b0;
    expect_svc(1, 16'h0111);
    pulse(1, 16'h0111);
    repeat (6) tick();
    check("t4_inten_pend", 64'(pending), 64'b0010);
    check("t4_inten_irq",  64'(irq),     64'd0);
    intEn = 1'b1;
    tick();
    check("t4_inten_rise", 64'(irq), 64'd1);
    ack_irq();
    repeat (3) tick();

    // Event on the served source in the same cycle as its ack
    expect_svc(0, 16'h00F0);
    pulse(0, 16'h00F0);
    wait_irq("t5_irq");
    repeat (2) tick();
    expect_svc(0, 16'h0F0F);
    srcData[0*DW +: DW] = 16'h0F0F;
    srcReq[0] = 1'b1;
    tick();
    srcReq[0] = 1'b0;
    tick();
    turnOffIRQ = 1'b1;
    tick();
    turnOffIRQ = 1'b0;
    check("t5_pend_kept", 64'(pending),  64'b0001);
    check("t5_ovf",       64'(overflow), 64'd0);
    check("t5_irq_off",   64'(irq),      64'd0);
    gap_len("t5_gap");
    ack_irq();
    repeat (3) tick();

    // Reset while irq is high, with the request line held high through it
    expect_svc(3, 16'h3C3C);
    srcData[3*DW +: DW] = 16'h3C3C;
    srcReq[3] = 1'b1;
    wait_irq("t6_irq");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t6_irq",      64'(irq),      64'd0);
    check("t6_pending",  64'(pending),  64'd0);
    check("t6_overflow", 64'(overflow), 64'd0);
    check("t6_intSrc",   64'(intSrc),   64'd0);
    check("t6_intAddr",  64'(intAddr),  64'd0);
    check("t6_intData",  64'(intData),  64'd0);
    repeat (8) tick();
    check("t6_level_irq",  64'(irq),     64'd0);
    check("t6_level_pend", 64'(pending), 64'd0);
    srcReq[3] = 1'b0;
    repeat (3) tick();
    expect_svc(3, 16'h3C3C);
    srcReq[3] = 1'b1;
    repeat (3) tick();
    check("t6_retoggle_edge3", 64'(irq), 64'd0);
    tick();
    check("t6_retoggle_edge4", 64'(irq), 64'd1);
    ack_irq();
    srcReq = '0;
    repeat (4) tick();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt controller serving the rcpu interrupt interface (irq, turnOffIRQ, intAddr, intData).
- Replaces the hard-wired two-source irq latch (keyboard + breakpoint) with an N-source controller. Each source has its own synchroniser, rising-edge detector, data capture, pending bit, enable mask and overflow flag.
- Sources are served one at a time by fixed priority (lowest index wins).

Parameters:
- N_SRC, 4, number of interrupt sources (1..16)
- DATA_W, 16, width of per-source interrupt data
- ADDR_W, 32, width of the interrupt vector address
- SYNC_STAGES, 2, synchroniser flops per request line (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on rising clk)
- srcReq  in  N_SRC  asynchronous request lines; a rising edge is an event
- srcData  in  N_SRC*DATA_W  per-source data, slice i = bits [i*DATA_W +: DATA_W]
- srcEn  in  N_SRC  per-source enable mask
- intEn  in  1  CPU global interrupt enable
- vecBase  in  ADDR_W  interrupt vector base address
- turnOffIRQ  in  1  CPU acknowledge, single-cycle pulse
- irq  out  1  interrupt request to CPU
- intData  out  DATA_W  data of the source being served
- intAddr  out  ADDR_W  vector address = vecBase + served index
- intSrc  out  4  index of the source being served
- pending  out  N_SRC  pending bits
- overflow  out  N_SRC  sticky per-source overflow flags

Behaviour:
- Reset (rst==0, any state): clears all sync flops, edge history, pending, overflow, captured data and outputs; irq=0, intData=0, intAddr=0, intSrc=0; FSM goes to IDLE. An in-flight interrupt is dropped without an ack.
- Synchroniser: each srcReq[i] passes through SYNC_STAGES flops, then a history flop.
  - edge[i] = last sync stage & !history.
  - Level-high at reset release produces no edge until the line goes low, then high again.
- Capture on edge[i]:
  - srcEn[i]=0: edge discarded; no state changes.
  - srcEn[i]=1 and pending[i]=0: pending[i]<=1; data[i]<=srcData slice, sampled in the edge cycle.
  - srcEn[i]=1 and pending[i]=1: overflow[i]<=1; data[i] is kept (first event wins).
- Clearing srcEn[i] while pending[i]=1 keeps the bit pending but makes it ineligible for arbitration.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: if intEn=1 and (pending & srcEn)!=0, choose the lowest set index k. Next cycle: irq=1, intSrc=k, intData=data[k], intAddr=vecBase+k (zero-extended, modulo 2^ADDR_W). Go to ASSERT.
  - IDLE with intEn=0: no assertion; pending bits are kept.
  - ASSERT: irq, intSrc, intData and intAddr are held stable. intEn, srcEn, vecBase and new edges do not change them. A higher-priority arrival does not preempt.
  - ASSERT with turnOffIRQ=1: next cycle irq=0, pending[k]<=0, overflow[k]<=0. Go to GAP.
  - GAP: exactly one cycle with irq=0, then IDLE. IDLE re-arbitrates in that same cycle, so the minimum irq-low time between services is 2 cycles.
  - turnOffIRQ in IDLE or GAP is ignored.
- Ack collision: an edge on k in the same cycle as its ack sets pending[k]=1 and captures the new data; set wins over clear. overflow[k] is cleared.
- Latency: srcReq rises before clock edge 1. The edge is detected in cycle SYNC_STAGES, pending is set after edge SYNC_STAGES+1, and irq is high after edge SYNC_STAGES+2 (4 edges at the default).
- intData, intAddr and intSrc hold their last values while irq=0.
- All outputs are registered.

Test Plan:
- Defaults; reset; srcEn=4'hF; intEn=1; vecBase=32'h0000_0100; srcData[1]=16'h00A5; pulse srcReq[1] -> irq=1 on the 4th clk after the rise, intSrc=1, intAddr=32'h101, intData=16'h00A5, pending=4'b0010; turnOffIRQ pulse -> irq=0 the next cycle, pending=0.
- srcReq[3] and srcReq[0] rise in the same cycle -> source 0 served first. After ack, irq is low for exactly 2 cycles, then irq=1 with intSrc=3.
- While source 2 is pending, pulse srcReq[2] twice (data 16'h1111, then 16'h2222) -> overflow[2]=1, intData=16'h1111; ack clears overflow[2].
- srcEn[2]=0, pulse srcReq[2] -> no pending, irq stays 0. intEn=0 with source 1 pending -> irq stays 0; raise intEn -> irq after 1 cycle.
- Source 0 edge arrives in the same cycle as the ack of source 0 -> pending[0] stays 1 with the new data; re-served after GAP.
- Assert rst=0 for one clk while irq=1 -> irq=0, pending=0, overflow=0, FSM in IDLE; srcReq held high through reset -> no interrupt until it toggles low, then high.
